nand_tree_pipe: RTL and testbench

- Parametrised, pipelined wide NAND/NOR reduction; successor to the fixed 4-input combinational NAND cell.
- Reduces WIDTH inputs through a radix-4 AND tree, with one register stage per tree level.
- Adds a per-bit input mask, a per-transaction NAND/NOR mode, and a valid/ready handshake with backpressure.
- Sits in the mcu9t5v0 library as a soft macro for wide decode and compare terms.

---
 rtl/nand_tree_pipe.sv | 140 ++++++++++++++
 tb/tb_nand_tree_pipe.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nand_tree_pipe.sv
// rtl/nand_tree_pipe.sv - pipelined radix-4 masked NAND/NOR reduction with valid/ready flow control
module nand_tree_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] MASK,
    input  logic             MODE,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic             ZN,
    output logic             OUT_VALID,
    input  logic             OUT_READY
);

    // Tree depth: smallest L >= 1 with 4**L >= WIDTH.
    function automatic int calc_levels(input int w);
        int l;
        int span;
        l    = 1;
        span = 4;
        while (span < w) begin
            span = span * 4;
            l    = l + 1;
        end
        return l;
    endfunction

    localparam int LEVELS = calc_levels(WIDTH);

    // Number of live bits at tree level k (level 0 is the normalised input).
    function automatic int level_cnt(input int k);
        int n;
        n = WIDTH;
        for (int i = 0; i < k; i++) begin
            n = (n + 3) / 4;
        end
        return n;
    endfunction

    logic [WIDTH-1:0]  x;
    logic [LEVELS-1:0] stage_valid;
    logic [LEVELS-1:0] stage_load;

    // Masked bits become 1 so they never control the AND; NOR mode inverts live data.
    always_comb begin
        x = MODE ? (~A | ~MASK) : (A | ~MASK);
    end

    // A stage may load when it or any stage after it is empty, or the consumer takes the head.
    always_comb begin : load_chain
        logic full_above;
        full_above = 1'b1;
        stage_load = '0;
        for (int s = LEVELS - 1; s >= 0; s--) begin
            full_above    = full_above & stage_valid[s];
            stage_load[s] = ~full_above | OUT_READY;
        end
    end

    genvar s;
    generate
        for (s = 0; s < LEVELS; s++) begin : g_stage
            localparam int NIN  = level_cnt(s);
            localparam int NOUT = level_cnt(s + 1);

            logic [NIN-1:0]    d_in;
            logic              v_in;
            logic              m_in;
            logic [4*NOUT-1:0] padded;
            logic [NOUT-1:0]   red;
            logic [NOUT-1:0]   q;
            logic              v_q;

            if (s == 0) begin : g_src
                assign d_in = x;
                assign v_in = IN_VALID;
                assign m_in = MODE;
            end else begin : g_src
                assign d_in = g_stage[s-1].q;
                assign v_in = stage_valid[s-1];
                assign m_in = g_stage[s-1].g_reg.m_q;
            end

            // Fill the ragged top group with ones so it is non-controlling.
            always_comb begin
                padded           = '1;
                padded[NIN-1:0]  = d_in;
            end

            // AND each LSB-aligned group of four into one bit of the next level.
            always_comb begin
                red = '0;
                for (int j = 0; j < NOUT; j++) begin
                    red[j] = &padded[4*j +: 4];
                end
            end

            if (s == LEVELS - 1) begin : g_reg
                // Last stage folds the NAND inversion into its load so ZN is a pure register.
                always_ff @(posedge CLK or negedge RN) begin
                    if (!RN) begin
                        q <= '0;
                    end else if (stage_load[s] && v_in) begin
                        q <= m_in ? red : ~red;
                    end
                end
            end else begin : g_reg
                logic m_q;
                // Inner stage captures its partial ANDs and the mode travelling with them.
                always_ff @(posedge CLK or negedge RN) begin
                    if (!RN) begin
                        q   <= '0;
                        m_q <= 1'b0;
                    end else if (stage_load[s] && v_in) begin
                        q   <= red;
                        m_q <= m_in;
                    end
                end
            end

            // Occupancy bit: follows the upstream valid whenever the stage is allowed to load.
            always_ff @(posedge CLK or negedge RN) begin
                if (!RN) begin
                    v_q <= 1'b0;
                end else if (stage_load[s]) begin
                    v_q <= v_in;
                end
            end

            assign stage_valid[s] = v_q;
        end
    endgenerate

    assign IN_READY  = stage_load[0];
    assign OUT_VALID = stage_valid[LEVELS-1];
    assign ZN        = g_stage[LEVELS-1].q[0];

endmodule

// File: tb/tb_nand_tree_pipe.sv
// tb/tb_nand_tree_pipe.sv - randomized self-checking bench for nand_tree_pipe
module tb_nand_tree_pipe;

    logic        clk = 1'b0;
    logic        rn;
    logic [15:0] a16;
    logic [15:0] mask16;
    logic        mode;
    logic        in_valid;
    logic        in_ready;
    logic        zn;
    logic        out_valid;
    logic        out_ready;

    logic [63:0] sw_a;
    logic [63:0] sw_mask;
    logic        sw_mode;
    logic        sw_valid;
    logic        sw_out_ready;
    logic [4:0]  sw_in_ready;
    logic [4:0]  sw_zn;
    logic [4:0]  sw_out_valid;

    int n_vec = 0;
    int n_err = 0;

    int wid[5]     = '{2, 4, 5, 17, 64};
    int lat_exp[5] = '{1, 1, 2, 3, 3};

    typedef struct {
        logic        v;
        logic [63:0] a;
        logic [63:0] m;
        logic        md;
    } stim_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] m;
        logic        md;
        logic        exp;
    } dvec_t;

    always #5 clk = ~clk;

    nand_tree_pipe #(.WIDTH(16)) u_dut (
        .CLK       (clk),
        .RN        (rn),
        .A         (a16),
        .MASK      (mask16),
        .MODE      (mode),
        .IN_VALID  (in_valid),
        .IN_READY  (in_ready),
        .ZN        (zn),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready)
    );

    for (genvar g = 0; g < 5; g++) begin : g_sw
        localparam int W = (g == 0) ? 2 : (g == 1) ? 4 : (g == 2) ? 5 : (g == 3) ? 17 : 64;
        nand_tree_pipe #(.WIDTH(W)) u_sw (
            .CLK       (clk),
            .RN        (rn),
            .A         (sw_a[W-1:0]),
            .MASK      (sw_mask[W-1:0]),
            .MODE      (sw_mode),
            .IN_VALID  (sw_valid),
            .IN_READY  (sw_in_ready[g]),
            .ZN        (sw_zn[g]),
            .OUT_VALID (sw_out_valid[g]),
            .OUT_READY (sw_out_ready)
        );
    end

    // NAND: some participating bit is 0. NOR: no participating bit is 1.
    function automatic logic model_zn(input logic [63:0] a, input logic [63:0] m,
                                      input logic md, input int w);
        logic [63:0] wm;
        logic [63:0] mm;
        wm = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        mm = m & wm;
        if (!md) return (a & mm) != mm;
        return (a & mm) == 64'd0;
    endfunction

    function automatic logic [63:0] rand_vec(input int hi);
        logic [63:0] v;
        case ($urandom_range(0, 3))
            0:       v = '1;
            1:       v = ~(64'd1 << $urandom_range(0, hi));
            2:       v = {$urandom, $urandom};
            default: v = 64'd1 << $urandom_range(0, hi);
        endcase
        return v;
    endfunction

    function automatic logic [63:0] rand_mask(input int hi);
        logic [63:0] v;
        case ($urandom_range(0, 3))
            0, 1:    v = '1;
            2:       v = {$urandom, $urandom};
            default: v = ~(64'd1 << $urandom_range(0, hi));
        endcase
        return v;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_rand16();
        logic [63:0] v;
        v      = rand_vec(15);
        a16    = v[15:0];
        v      = rand_mask(15);
        mask16 = v[15:0];
    endtask

    task automatic test_reset();
        rn = 1'b0; a16 = '0; mask16 = '0; mode = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        sw_a = '0; sw_mask = '0; sw_mode = 1'b0; sw_valid = 1'b0; sw_out_ready = 1'b0;
        cyc();
        cyc();
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b expected 0", out_valid); end
        n_vec++;
        if (zn !== 1'b0) begin n_err++; $display("FAIL reset_zn got %b expected 0", zn); end
        n_vec++;
        if (sw_out_valid !== 5'b0) begin n_err++; $display("FAIL reset_sweep_out_valid got %b expected 00000", sw_out_valid); end
        n_vec++;
        if (sw_zn !== 5'b0) begin n_err++; $display("FAIL reset_sweep_zn got %b expected 00000", sw_zn); end
        rn = 1'b1;
    endtask

    task automatic test_directed();
        dvec_t tab[7];
        int    lat;
        logic [15:0] r;
        r = 16'($urandom);
        tab[0] = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b0};
        tab[1] = '{16'hFFFE, 16'hFFFF, 1'b0, 1'b1};
        tab[2] = '{16'h0000, 16'hFFFF, 1'b1, 1'b1};
        tab[3] = '{16'h0100, 16'hFFFF, 1'b1, 1'b0};
        tab[4] = '{16'h0100, 16'hFEFF, 1'b1, 1'b1};
        tab[5] = '{r,        16'h0000, 1'b0, 1'b0};
        tab[6] = '{~r,       16'h0000, 1'b1, 1'b1};
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            a16 = tab[i].a; mask16 = tab[i].m; mode = tab[i].md; in_valid = 1'b1;
            #1;
            n_vec++;
            if (in_ready !== 1'b1) begin n_err++; $display("FAIL directed_in_ready[%0d] got %b expected 1", i, in_ready); end
            cyc();
            in_valid = 1'b0;
            a16 = 16'($urandom); mask16 = 16'($urandom); mode = ~mode;
            lat = 1;
            while (out_valid !== 1'b1 && lat < 10) begin
                cyc();
                lat++;
            end
            n_vec++;
            if (lat != 2) begin n_err++; $display("FAIL directed_latency[%0d] got %0d expected 2", i, lat); end
            n_vec++;
            if (zn !== tab[i].exp) begin n_err++; $display("FAIL directed_zn[%0d] A=%h MASK=%h MODE=%b got %b expected %b", i, tab[i].a, tab[i].m, tab[i].md, zn, tab[i].exp); end
            cyc();
            n_vec++;
            if (out_valid !== 1'b0) begin n_err++; $display("FAIL directed_drain[%0d] out_valid got %b expected 0", i, out_valid); end
        end
    endtask

    task automatic test_back_to_back();
        logic q[$];
        logic e;
        int   sent = 0, got = 0, first_c = -1, last_c = -1;
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (sent < 8) begin
                drive_rand16();
                mode = sent[0];
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid === 1'b1) begin
                n_vec++;
                if (q.size() == 0) begin
                    n_err++; $display("FAIL b2b_extra_result got result with zn=%b expected none", zn);
                end else begin
                    e = q.pop_front();
                    if (zn !== e) begin n_err++; $display("FAIL b2b_zn[%0d] got %b expected %b", got, zn, e); end
                end
                if (first_c < 0) first_c = c;
                last_c = c;
                got++;
            end
            if (in_valid) begin
                n_vec++;
                if (in_ready !== 1'b1) begin
                    n_err++; $display("FAIL b2b_in_ready[%0d] got %b expected 1", sent, in_ready);
                end else begin
                    q.push_back(model_zn({48'd0, a16}, {48'd0, mask16}, mode, 16));
                    sent++;
                end
            end
            cyc();
        end
        n_vec++;
        if (got != 8) begin n_err++; $display("FAIL b2b_count got %0d expected 8", got); end
        n_vec++;
        if (last_c - first_c != 7) begin n_err++; $display("FAIL b2b_consecutive span got %0d expected 7", last_c - first_c); end
    endtask

    task automatic test_backpressure();
        logic q[$];
        logic e;
        int   sent = 0, got = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            drive_rand16();
            mode = 1'($urandom_range(0, 1));
            in_valid = 1'b1;
            #1;
            n_vec++;
            if (out_valid !== (c >= 2)) begin n_err++; $display("FAIL stall_out_valid[%0d] got %b expected %b", c, out_valid, (c >= 2)); end
            if (c >= 2 && q.size() > 0) begin
                n_vec++;
                if (zn !== q[0]) begin n_err++; $display("FAIL stall_zn_hold[%0d] got %b expected %b", c, zn, q[0]); end
            end
            if (in_ready === 1'b1) begin
                q.push_back(model_zn({48'd0, a16}, {48'd0, mask16}, mode, 16));
                sent++;
            end
            cyc();
        end
        n_vec++;
        if (sent != 2) begin n_err++; $display("FAIL stall_accepts got %0d expected 2", sent); end
        n_vec++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready got %b expected 0", in_ready); end
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            in_valid = (sent < 6);
            if (in_valid) begin
                drive_rand16();
                mode = 1'($urandom_range(0, 1));
            end
            #1;
            if (c == 0) begin
                n_vec++;
                if (in_ready !== 1'b1) begin n_err++; $display("FAIL release_in_ready got %b expected 1", in_ready); end
            end
            if (out_valid === 1'b1) begin
                n_vec++;
                if (q.size() == 0) begin
                    n_err++; $display("FAIL release_extra_result got result with zn=%b expected none", zn);
                end else begin
                    e = q.pop_front();
                    if (zn !== e) begin n_err++; $display("FAIL release_zn[%0d] got %b expected %b", got, zn, e); end
                end
                got++;
            end
            if (in_valid && in_ready === 1'b1) begin
                q.push_back(model_zn({48'd0, a16}, {48'd0, mask16}, mode, 16));
                sent++;
            end
            cyc();
        end
        n_vec++;
        if (got != 6) begin n_err++; $display("FAIL release_count got %0d expected 6", got); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        a16 = 16'h0000; mask16 = 16'hFFFF; mode = 1'b0; in_valid = 1'b1;
        cyc();
        a16 = 16'hFFFF;
        cyc();
        in_valid = 1'b0;
        n_vec++;
        if (out_valid !== 1'b1 || zn !== 1'b1) begin n_err++; $display("FAIL midreset_preload got valid=%b zn=%b expected valid=1 zn=1", out_valid, zn); end
        #3;
        rn = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL midreset_async_valid got %b expected 0", out_valid); end
        n_vec++;
        if (zn !== 1'b0) begin n_err++; $display("FAIL midreset_async_zn got %b expected 0", zn); end
        cyc();
        cyc();
        rn = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            cyc();
            n_vec++;
            if (out_valid !== 1'b0) begin n_err++; $display("FAIL midreset_stale[%0d] got %b expected 0", c, out_valid); end
        end
    endtask

    task automatic test_sweep();
        stim_t hist[$];
        stim_t st;
        int    acc = 0, idle = 0;
        logic  ev, ez;
        sw_out_ready = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            for (int g = 0; g < 5; g++) begin
                ev = 1'b0;
                ez = 1'b0;
                if (c >= lat_exp[g]) begin
                    st = hist[c - lat_exp[g]];
                    ev = st.v;
                    ez = model_zn(st.a, st.m, st.md, wid[g]);
                end
                n_vec++;
                if (sw_out_valid[g] !== ev) begin
                    n_err++; $display("FAIL sweep_valid w=%0d cycle=%0d got %b expected %b", wid[g], c, sw_out_valid[g], ev);
                end else if (ev) begin
                    n_vec++;
                    if (sw_zn[g] !== ez) begin
                        n_err++; $display("FAIL sweep_zn w=%0d cycle=%0d a=%h m=%h mode=%b got %b expected %b", wid[g], c, st.a, st.m, st.md, sw_zn[g], ez);
                    end
                end
            end
            if (acc >= 1000) begin
                if (idle > 4) break;
                idle++;
            end
            st.v  = (acc < 1000) && ($urandom_range(0, 7) != 0);
            st.a  = rand_vec($urandom_range(0, 1) ? 4 : 63);
            st.m  = rand_mask($urandom_range(0, 1) ? 4 : 63);
            st.md = 1'($urandom_range(0, 1));
            hist.push_back(st);
            sw_a = st.a; sw_mask = st.m; sw_mode = st.md; sw_valid = st.v;
            #1;
            if (st.v) begin
                n_vec++;
                if (sw_in_ready !== 5'b11111) begin n_err++; $display("FAIL sweep_in_ready cycle=%0d got %b expected 11111", c, sw_in_ready); end
                acc++;
            end
            cyc();
        end
        n_vec++;
        if (acc != 1000) begin n_err++; $display("FAIL sweep_vector_count got %0d expected 1000", acc); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
